// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID operand bypass
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [7:0]        id_ctrl_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [4:0]        id_rs_addr_i,
  input  logic [4:0]        id_rt_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic              wb_regwrite_i,
  input  logic [4:0]        wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              ex_valid_o,
  output logic [7:0]        ex_ctrl_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rs_addr_o,
  output logic [4:0]        ex_rt_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Bit position of MemRead inside the packed control byte.
  localparam int MEMREAD_BIT = 5;

  logic              hz;
  logic              bubble;
  logic              count_stall;
  logic [DATA_W-1:0] rs_data_next;
  logic [DATA_W-1:0] rt_data_next;

  assign hz = id_valid_i & ex_valid_o & ex_ctrl_o[MEMREAD_BIT] & (ex_rt_addr_o != 5'd0) &
              ((ex_rt_addr_o == id_rs_addr_i) | (ex_rt_addr_o == id_rt_addr_i));

  // Flush squashes the same slot the hazard would bubble, so it also releases the PC.
  assign pc_write_o    = ~hold_i & ~(hz & ~flush_i);
  assign if_id_write_o = pc_write_o;

  assign bubble      = flush_i | hz;
  assign count_stall = hz & ~flush_i & (stall_cnt_o != {CNT_W{1'b1}});

  always_comb begin
    rs_data_next = id_rs_data_i;
    rt_data_next = id_rt_data_i;
    if (wb_regwrite_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == id_rs_addr_i))
      rs_data_next = wb_data_i;
    if (wb_regwrite_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == id_rt_addr_i))
      rt_data_next = wb_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= 8'd0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_addr_o <= 5'd0;
      ex_rt_addr_o <= 5'd0;
      ex_rd_addr_o <= 5'd0;
      stall_cnt_o  <= '0;
    end else if (!hold_i) begin
      if (bubble) begin
        ex_valid_o   <= 1'b0;
        ex_ctrl_o    <= 8'd0;
        ex_rs_data_o <= '0;
        ex_rt_data_o <= '0;
        ex_imm_o     <= '0;
        ex_rs_addr_o <= 5'd0;
        ex_rt_addr_o <= 5'd0;
        ex_rd_addr_o <= 5'd0;
        if (count_stall)
          stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ex_valid_o   <= id_valid_i;
        ex_ctrl_o    <= id_valid_i ? id_ctrl_i : 8'd0;
        ex_rs_data_o <= rs_data_next;
        ex_rt_data_o <= rt_data_next;
        ex_imm_o     <= id_imm_i;
        ex_rs_addr_o <= id_rs_addr_i;
        ex_rt_addr_o <= id_rt_addr_i;
        ex_rd_addr_o <= id_rd_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the EX slot and stall counter.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [7:0] LW_CTRL = 8'hE8;
  localparam logic [7:0] R_CTRL  = 8'h85;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, hold, flush, id_valid, wb_regwrite;
  logic [7:0]        id_ctrl;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, wb_data;
  logic [4:0]        id_rs_addr, id_rt_addr, id_rd_addr, wb_rd_addr;

  logic              ex_valid_o, pc_write_o, if_id_write_o;
  logic [7:0]        ex_ctrl_o;
  logic [DATA_W-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]        ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  logic              s_valid, s_pc_write, s_if_id_write;
  logic [7:0]        s_ctrl;
  logic [DATA_W-1:0] s_rs_data, s_rt_data, s_imm;
  logic [4:0]        s_rs_addr, s_rt_addr, s_rd_addr;
  logic [1:0]        s_cnt;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .flush_i(flush),
    .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr), .id_rd_addr_i(id_rd_addr),
    .wb_regwrite_i(wb_regwrite), .wb_rd_addr_i(wb_rd_addr), .wb_data_i(wb_data),
    .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation checks.
  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .flush_i(flush),
    .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr), .id_rd_addr_i(id_rd_addr),
    .wb_regwrite_i(wb_regwrite), .wb_rd_addr_i(wb_rd_addr), .wb_data_i(wb_data),
    .ex_valid_o(s_valid), .ex_ctrl_o(s_ctrl),
    .ex_rs_data_o(s_rs_data), .ex_rt_data_o(s_rt_data), .ex_imm_o(s_imm),
    .ex_rs_addr_o(s_rs_addr), .ex_rt_addr_o(s_rt_addr), .ex_rd_addr_o(s_rd_addr),
    .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write), .stall_cnt_o(s_cnt)
  );

  typedef struct packed {
    logic              valid;
    logic [7:0]        ctrl;
    logic [DATA_W-1:0] rs, rt, imm;
    logic [4:0]        rsa, rta, rda;
  } ex_t;

  ex_t         m;
  int unsigned m_cnt, m_cnt2;
  int          checks = 0;
  int          errors = 0;

  function automatic ex_t dut_ex();
    ex_t r;
    r.valid = ex_valid_o;   r.ctrl = ex_ctrl_o;
    r.rs = ex_rs_data_o;    r.rt = ex_rt_data_o;   r.imm = ex_imm_o;
    r.rsa = ex_rs_addr_o;   r.rta = ex_rt_addr_o;  r.rda = ex_rd_addr_o;
    return r;
  endfunction

  // The instruction in ID reads the register a load currently in EX will produce.
  function automatic logic model_hz();
    return id_valid && m.valid && m.ctrl[5] && m.rta != 5'd0 &&
           (m.rta == id_rs_addr || m.rta == id_rt_addr);
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [4:0] a, input logic [DATA_W-1:0] rf);
    return (wb_regwrite && wb_rd_addr != 5'd0 && wb_rd_addr == a) ? wb_data : rf;
  endfunction

  task automatic model_reset();
    m = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // Advance one clock edge and move the model to the state that edge should produce.
  task automatic tick();
    ex_t nxt;
    logic hz;
    nxt = m;
    hz  = model_hz();
    if (!hold) begin
      if (flush || hz) begin
        nxt = '0;
        if (!flush) begin
          if (m_cnt  < 65535) m_cnt++;
          if (m_cnt2 < 3)     m_cnt2++;
        end
      end else begin
        nxt.valid = id_valid;
        nxt.ctrl  = id_valid ? id_ctrl : 8'h00;
        nxt.rs    = model_read(id_rs_addr, id_rs_data);
        nxt.rt    = model_read(id_rt_addr, id_rt_data);
        nxt.imm   = id_imm;
        nxt.rsa   = id_rs_addr; nxt.rta = id_rt_addr; nxt.rda = id_rd_addr;
      end
    end
    @(posedge clk); #1;
    m = nxt;
  endtask

  task automatic set_id(input logic v, input logic [7:0] c, input logic [4:0] rsa, rta, rda,
                        input logic [DATA_W-1:0] rsd, rtd, imm);
    id_valid = v; id_ctrl = c; id_rs_addr = rsa; id_rt_addr = rta; id_rd_addr = rda;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  // Clear EX with a flush, then put a lw writing register rt into EX.
  task automatic load_lw(input logic [4:0] rt);
    flush = 1'b1; tick(); flush = 1'b0;
    set_id(1'b1, LW_CTRL, 5'd1, rt, 5'd0, 32'h0, 32'h0, 32'h4);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 0; flush = 0; wb_regwrite = 0; wb_rd_addr = 0; wb_data = 0;
    set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_ex() !== ex_t'(0)) begin errors++; $display("FAIL reset_ex got=%h want=0", dut_ex()); end
    checks++;
    if (stall_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt_o); end
    checks++;
    if (pc_write_o !== 1'b1 || if_id_write_o !== 1'b1) begin
      errors++; $display("FAIL reset_pcw got=%b/%b want=1/1", pc_write_o, if_id_write_o);
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_reset_midstream();
    set_id(1'b1, 8'hFF, 5'd3, 5'd4, 5'd6, 32'h12345678, 32'h9, 32'h1);
    tick();
    checks++;
    if (ex_ctrl_o !== 8'hFF || ex_rs_data_o !== 32'h12345678) begin
      errors++; $display("FAIL mid_load got ctrl=%h rs=%h want ctrl=ff rs=12345678", ex_ctrl_o, ex_rs_data_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_ex() !== ex_t'(0) || stall_cnt_o !== '0) begin
      errors++; $display("FAIL mid_reset got=%h cnt=%0d want=0", dut_ex(), stall_cnt_o);
    end
    checks++;
    if (pc_write_o !== 1'b1) begin errors++; $display("FAIL mid_reset_pcw got=%b want=1", pc_write_o); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    $display("test_reset_midstream done");
  endtask

  task automatic test_load_use();
    int unsigned base;
    load_lw(5'd2);
    set_id(1'b1, R_CTRL, 5'd2, 5'd7, 5'd9, 32'hA, 32'hB, 32'hC);
    #1;
    checks++;
    if (pc_write_o !== 1'b0 || if_id_write_o !== 1'b0) begin
      errors++; $display("FAIL lu_stall got=%b/%b want=0/0", pc_write_o, if_id_write_o);
    end
    base = m_cnt;
    tick();
    checks++;
    if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 8'h00 || stall_cnt_o !== 16'(base + 1)) begin
      errors++; $display("FAIL lu_bubble got v=%b c=%h cnt=%0d want v=0 c=00 cnt=%0d",
                         ex_valid_o, ex_ctrl_o, stall_cnt_o, base + 1);
    end
    checks++;
    if (pc_write_o !== 1'b1) begin errors++; $display("FAIL lu_release got=%b want=1", pc_write_o); end
    tick();
    checks++;
    if (ex_rs_addr_o !== 5'd2 || ex_ctrl_o !== R_CTRL || ex_valid_o !== 1'b1) begin
      errors++; $display("FAIL lu_dep got rsa=%0d c=%h v=%b want rsa=2 c=%h v=1",
                         ex_rs_addr_o, ex_ctrl_o, ex_valid_o, R_CTRL);
    end
    load_lw(5'd0);
    set_id(1'b1, R_CTRL, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (pc_write_o !== 1'b1) begin errors++; $display("FAIL lu_rt0 got=%b want=1", pc_write_o); end
    load_lw(5'd2);
    set_id(1'b1, R_CTRL, 5'd3, 5'd4, 5'd9, 32'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (pc_write_o !== 1'b1) begin errors++; $display("FAIL lu_nodep got=%b want=1", pc_write_o); end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_flush_hazard();
    int unsigned base;
    load_lw(5'd2);
    set_id(1'b1, R_CTRL, 5'd6, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    checks++;
    if (pc_write_o !== 1'b1) begin errors++; $display("FAIL fh_pcw got=%b want=1", pc_write_o); end
    base = m_cnt;
    tick();
    flush = 1'b0;
    checks++;
    if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 8'h00 || stall_cnt_o !== 16'(base)) begin
      errors++; $display("FAIL fh_bubble got v=%b c=%h cnt=%0d want v=0 c=00 cnt=%0d",
                         ex_valid_o, ex_ctrl_o, stall_cnt_o, base);
    end
    $display("test_flush_hazard done");
  endtask

  task automatic test_hold();
    int unsigned base;
    load_lw(5'd2);
    set_id(1'b1, R_CTRL, 5'd2, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0);
    hold = 1'b1;
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc_write_o !== 1'b0) begin errors++; $display("FAIL hold_pcw[%0d] got=%b want=0", i, pc_write_o); end
      tick();
      checks++;
      if (ex_valid_o !== 1'b1 || ex_ctrl_o !== LW_CTRL || ex_rt_addr_o !== 5'd2 || stall_cnt_o !== 16'(base)) begin
        errors++; $display("FAIL hold_frozen[%0d] got v=%b c=%h rta=%0d cnt=%0d want v=1 c=%h rta=2 cnt=%0d",
                           i, ex_valid_o, ex_ctrl_o, ex_rt_addr_o, stall_cnt_o, LW_CTRL, base);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (pc_write_o !== 1'b0) begin errors++; $display("FAIL hold_rel_pcw got=%b want=0", pc_write_o); end
    tick();
    checks++;
    if (ex_valid_o !== 1'b0 || stall_cnt_o !== 16'(base + 1)) begin
      errors++; $display("FAIL hold_stall got v=%b cnt=%0d want v=0 cnt=%0d", ex_valid_o, stall_cnt_o, base + 1);
    end
    tick();
    checks++;
    if (ex_ctrl_o !== R_CTRL || stall_cnt_o !== 16'(base + 1)) begin
      errors++; $display("FAIL hold_dep got c=%h cnt=%0d want c=%h cnt=%0d", ex_ctrl_o, stall_cnt_o, R_CTRL, base + 1);
    end
    $display("test_hold done");
  endtask

  task automatic test_wb_bypass();
    logic [4:0]        rw_rd [4]  = '{5'd5, 5'd0, 5'd5, 5'd5};
    logic              rw_en [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0]        rt_a  [4]  = '{5'd5, 5'd5, 5'd5, 5'd6};
    logic [DATA_W-1:0] exp_rs[4]  = '{32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
    logic [DATA_W-1:0] exp_rt[4]  = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, R_CTRL, 5'd5, rt_a[i], 5'd9, 32'h0, 32'h0, 32'h0);
      wb_regwrite = rw_en[i]; wb_rd_addr = rw_rd[i]; wb_data = 32'hDEADBEEF;
      tick();
      checks++;
      if (ex_rs_data_o !== exp_rs[i] || ex_rt_data_o !== exp_rt[i]) begin
        errors++; $display("FAIL wb_bypass[%0d] got rs=%h rt=%h want rs=%h rt=%h",
                           i, ex_rs_data_o, ex_rt_data_o, exp_rs[i], exp_rt[i]);
      end
    end
    wb_regwrite = 1'b0;
    $display("test_wb_bypass done");
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      load_lw(5'd2);
      set_id(1'b1, R_CTRL, 5'd2, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0);
      tick();
      checks++;
      if (s_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || stall_cnt_o !== 16'(i + 1)) begin
        errors++; $display("FAIL sat[%0d] got narrow=%0d wide=%0d want narrow=%0d wide=%0d",
                           i, s_cnt, stall_cnt_o, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
    end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    logic exp_pcw;
    for (int i = 0; i < 400; i++) begin
      hold        = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      id_valid    = ($urandom_range(0, 6) != 0);
      id_ctrl     = 8'($urandom);
      id_rs_addr  = 5'($urandom_range(0, 3));
      id_rt_addr  = 5'($urandom_range(0, 3));
      id_rd_addr  = 5'($urandom);
      id_rs_data  = $urandom;
      id_rt_data  = $urandom;
      id_imm      = $urandom;
      wb_regwrite = ($urandom_range(0, 1) == 1);
      wb_rd_addr  = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      #1;
      exp_pcw = !hold && !(model_hz() && !flush);
      checks++;
      if (pc_write_o !== exp_pcw || if_id_write_o !== exp_pcw) begin
        errors++; $display("FAIL rnd_pcw[%0d] got=%b/%b want=%b", i, pc_write_o, if_id_write_o, exp_pcw);
      end
      tick();
      checks++;
      if (dut_ex() !== m) begin errors++; $display("FAIL rnd_ex[%0d] got=%h want=%h", i, dut_ex(), m); end
      checks++;
      if (stall_cnt_o !== 16'(m_cnt) || s_cnt !== 2'(m_cnt2)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stall_cnt_o, s_cnt, m_cnt, m_cnt2);
      end
    end
    hold = 1'b0; flush = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_load_use();
    test_flush_hazard();
    test_hold();
    test_wb_bypass();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
